// File: rtl/adau1761_spi_responder.sv
// ADAU1761 control-port SPI slave backed by an internal 8-bit register file.
// SCLK/CS/SDI are oversampled in the clk domain; clk must run at least 4x SCLK.
module adau1761_spi_responder #(
  parameter logic [15:0] ADDR_BASE    = 16'h4000,
  parameter int          DEPTH        = 256,
  parameter int          INIT_TOGGLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        spi_mode,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err,
  input  logic [15:0] dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(INIT_TOGGLES + 1);
  localparam logic [16:0] ADDR_END = {1'b0, ADDR_BASE} + 17'(DEPTH);

  typedef enum logic [2:0] {IDLE, CHIP, ADDR_HI, ADDR_LO, DATA} state_t;
  state_t state_q, state_d;

  logic [1:0]    sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic          sclk_prev_q, cs_prev_q;
  logic [TW-1:0] tog_q;
  logic          spi_mode_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shin_q;
  logic [7:0]    shout_q;
  logic          rw_q, load_pend_q, sdo_oe_q;
  logic [15:0]   addr_q;
  logic          wr_stb_q, frame_err_q;
  logic [15:0]   wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    mem_q [DEPTH];

  logic sclk_s, cs_s, sdi_s;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [7:0] byte_val;
  logic byte_done, commit_wr, arm_load, out_fall;

  function automatic logic in_range(input logic [15:0] a);
    return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
  endfunction

  function automatic logic [AW-1:0] ofs(input logic [15:0] a);
    logic [15:0] d;
    d = a - ADDR_BASE;
    return d[AW-1:0];
  endfunction

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign sdi_s     = sdi_sync_q[1];
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  // A raised cs masks sclk edges, so a cs rise always beats a coincident edge.
  assign sclk_rise = ~cs_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~cs_s & ~sclk_s & sclk_prev_q;
  assign byte_val  = {shin_q, sdi_s};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall && spi_mode_q) state_d = CHIP;
        CHIP:    if (byte_done) state_d = ADDR_HI;
        ADDR_HI: if (byte_done) state_d = ADDR_LO;
        ADDR_LO: if (byte_done) state_d = DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    byte_done = (state_q != IDLE) && sclk_rise && (bit_cnt_q == 3'd7);
    commit_wr = byte_done && (state_q == DATA) && !rw_q;
    arm_load  = byte_done && rw_q && ((state_q == ADDR_LO) || (state_q == DATA));
    out_fall  = (state_q == DATA) && rw_q && sclk_fall;
    sdo       = sdo_oe_q & shout_q[7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sdi_sync_q  <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      tog_q       <= '0;
      spi_mode_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shin_q      <= '0;
      shout_q     <= '0;
      rw_q        <= 1'b0;
      load_pend_q <= 1'b0;
      sdo_oe_q    <= 1'b0;
      addr_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs};
      sdi_sync_q  <= {sdi_sync_q[0], sdi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_rise && !spi_mode_q) begin
        tog_q <= tog_q + 1'b1;
        if (tog_q == TW'(INIT_TOGGLES - 1)) spi_mode_q <= 1'b1;
      end
      if (cs_rise) begin
        bit_cnt_q   <= 3'd0;
        sdo_oe_q    <= 1'b0;
        load_pend_q <= 1'b0;
        if (bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
      end else if (state_q == IDLE) begin
        bit_cnt_q <= 3'd0;
      end else begin
        if (sclk_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shin_q    <= byte_val[6:0];
        end
        if (byte_done) begin
          case (state_q)
            CHIP:    rw_q         <= byte_val[0];
            ADDR_HI: addr_q[15:8] <= byte_val;
            ADDR_LO: addr_q[7:0]  <= byte_val;
            default: ;
          endcase
        end
        if (commit_wr) begin
          wr_stb_q  <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= byte_val;
          addr_q    <= addr_q + 16'd1;
        end
        if (arm_load) load_pend_q <= 1'b1;
        // Read data is fetched on the fall after the previous byte completes.
        if (out_fall) begin
          if (load_pend_q) begin
            shout_q     <= in_range(addr_q) ? mem_q[ofs(addr_q)] : 8'h00;
            sdo_oe_q    <= 1'b1;
            load_pend_q <= 1'b0;
            addr_q      <= addr_q + 16'd1;
          end else begin
            shout_q <= {shout_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (commit_wr && in_range(addr_q)) begin
      mem_q[ofs(addr_q)] <= byte_val;
    end
  end

  assign sdo_oe    = sdo_oe_q;
  assign spi_mode  = spi_mode_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign dbg_data  = in_range(dbg_addr) ? mem_q[ofs(dbg_addr)] : 8'h00;

endmodule

// File: tb/tb_adau1761_spi_responder.sv
// Bench for adau1761_spi_responder: directed and random SPI frames checked
// against a frame-level model of the codec register file.
module tb_adau1761_spi_responder;
  localparam logic [15:0] BASE  = 16'h4000;
  localparam int          DEPTH = 256;
  localparam int          HP    = 8;

  logic        clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic [15:0] dbg_addr = BASE;
  logic        sdo, sdo_oe, spi_mode, wr_stb, frame_err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, dbg_data;

  adau1761_spi_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .INIT_TOGGLES(3)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .spi_mode(spi_mode),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents and mode-entry bookkeeping.
  logic [7:0] ref_mem [DEPTH];
  int         ref_tog = 0;
  bit         ref_mode = 1'b0;

  function automatic bit ref_in(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + DEPTH);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_in(a) ? ref_mem[int'(a) - int'(BASE)] : 8'h00;
  endfunction

  logic [23:0] obs_wr [$];
  int          obs_ferr = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) obs_wr.push_back({wr_addr, wr_data});
    if (frame_err === 1'b1) obs_ferr++;
  end

  logic [7:0] tx_b [8];
  logic [7:0] rx_b [8];
  logic       oe_b [64];

  task automatic set_tx(input logic [39:0] v);
    for (int k = 0; k < 8; k++) tx_b[k] = (k < 5) ? v[39-8*k -: 8] : 8'h00;
  endtask

  // SPI mode 0 master; sdo/sdo_oe are sampled just before each rising sclk.
  task automatic spi_xfer(input int nbits, input bit hold);
    obs_wr.delete();
    obs_ferr = 0;
    cs = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = tx_b[i/8][7-(i%8)];
      repeat (HP) @(negedge clk);
      rx_b[i/8][7-(i%8)] = sdo;
      oe_b[i] = sdo_oe;
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HP) @(negedge clk);
    if (!hold) begin
      cs = 1'b1;
      repeat (2*HP) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int nbits);
    int          nfull, hdr_oe, dat_oe, dat_bits;
    bit          rd;
    logic [15:0] a;
    logic [23:0] exp_wr [$];
    nfull = nbits / 8;
    rd    = tx_b[0][0];
    a     = {tx_b[1], tx_b[2]};
    hdr_oe = 0;
    dat_oe = 0;
    if (ref_mode && !rd) begin
      for (int k = 3; k < nfull; k++) begin
        logic [15:0] wa;
        wa = a + 16'(k - 3);
        exp_wr.push_back({wa, tx_b[k]});
        if (ref_in(wa)) ref_mem[int'(wa) - int'(BASE)] = tx_b[k];
      end
    end
    for (int i = 0; i < nbits && i < 24; i++) hdr_oe += int'(oe_b[i]);
    for (int i = 24; i < nfull*8; i++) dat_oe += int'(oe_b[i]);
    dat_bits = (ref_mode && rd && nfull > 3) ? (nfull - 3) * 8 : 0;
    chk({tag, " hdr_oe"}, hdr_oe, 0);
    chk({tag, " dat_oe"}, dat_oe, dat_bits);
    if (ref_mode && rd) begin
      for (int k = 3; k < nfull; k++) chk({tag, " rd"}, rx_b[k], ref_rd(a + 16'(k - 3)));
    end
    chk({tag, " nwr"}, obs_wr.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++)
      chk({tag, " wr"}, obs_wr[k], exp_wr[k]);
    chk({tag, " ferr"}, obs_ferr, (ref_mode && (nbits % 8) != 0) ? 1 : 0);
    if (!ref_mode) begin
      ref_tog++;
      if (ref_tog >= 3) ref_mode = 1'b1;
    end
    chk({tag, " mode"}, spi_mode, ref_mode);
    dbg_addr = a;
    #1;
    chk({tag, " dbg"}, dbg_data, ref_rd(a));
  endtask

  task automatic run_frame(input string tag, input int nbits);
    spi_xfer(nbits, 1'b0);
    check_frame(tag, nbits);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " sdo"}, sdo, 0);
    chk({tag, " sdo_oe"}, sdo_oe, 0);
    chk({tag, " mode"}, spi_mode, 0);
    chk({tag, " wr_stb"}, wr_stb, 0);
    chk({tag, " wr_addr"}, wr_addr, 0);
    chk({tag, " wr_data"}, wr_data, 0);
    chk({tag, " ferr"}, frame_err, 0);
    dbg_addr = BASE;
    #1;
    chk({tag, " dbg"}, dbg_data, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Mode entry: a real write frame before mode does nothing, then two dummies.
    set_tx(40'h00_40_00_01_00); run_frame("pre_mode", 32);
    set_tx(40'h0);              run_frame("dummy1", 32);
    set_tx(40'h0);              run_frame("dummy2", 32);
    set_tx(40'h00_40_00_01_00); run_frame("wr1", 32);
    set_tx(40'h00_40_10_AA_BB); run_frame("burst_wr", 40);
    set_tx(40'h01_40_10_5A_C3); run_frame("burst_rd", 40);
    set_tx(40'h00_3F_FF_55_00); run_frame("oor_wr", 32);
    set_tx(40'h01_3F_FF_00_00); run_frame("oor_rd", 32);
    set_tx(40'h00_40_10_F0_00); run_frame("partial", 28);
    set_tx(40'h00_FF_FF_11_22); run_frame("wrap_wr", 40);

    // Reset in the middle of a write-data byte.
    set_tx(40'h00_40_00_E0_00);
    spi_xfer(28, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    chk("mid_rst nwr", obs_wr.size(), 0);
    cs = 1'b1;
    repeat (2*HP) @(negedge clk);
    chk("mid_rst ferr", obs_ferr, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_mode = 1'b0;
    ref_tog  = 1;
    chk("mid_rst mode", spi_mode, 0);
    set_tx(40'h00_40_00_07_00); run_frame("post_rst_nomode", 32);
    set_tx(40'h0);              run_frame("post_rst_dummy", 32);
    set_tx(40'h00_40_00_07_00); run_frame("post_rst_wr", 32);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] a;
      int          nd, nb;
      bit          rw;
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = BASE + 16'($urandom_range(0, DEPTH - 1));
        1:       a = BASE + 16'h10 + 16'($urandom_range(0, 7));
        2:       a = BASE + 16'(DEPTH - 2);
        3:       a = BASE - 16'($urandom_range(1, 2));
        default: a = 16'hFFFE + 16'($urandom_range(0, 1));
      endcase
      nd = $urandom_range(1, 3);
      tx_b[0] = {7'($urandom), rw};
      tx_b[1] = a[15:8];
      tx_b[2] = a[7:0];
      for (int k = 3; k < 8; k++) tx_b[k] = 8'($urandom);
      nb = 8 * (3 + nd);
      if ($urandom_range(0, 3) == 0) nb += $urandom_range(1, 7);
      run_frame("rnd", nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
